face_sweep_sequencer: RTL and testbench
=======================================

// Module: face_sweep_sequencer
// PURPOSE
//  Sequences ObjectMemory for the ray/triangle intersection stage. Per start, it sweeps face_cntr 0..FACE_CNT-1
//  and delivers each Face_t downstream on a valid/ready handshake. It absorbs the 1-cycle registered ROM
//  latency with a credit-limited 2-entry buffer, so stalls never drop or duplicate a face.
//  It sits between ObjectMemory and the intersection unit; one sweep equals one ray tested against the whole mesh.
// PARAMETERS
//  FACE_CNT  92  faces in the mesh; must match ObjectMemory.FACE_CNT; must be >= 2
//  AW        $clog2(FACE_CNT)  address width (derived, do not override)
// PORTS
//  clk         in   1        system clock, all logic on posedge
//  rst         in   1        synchronous, active-high reset
//  start       in   1        begin a sweep; accepted only when busy==0
//  abort       in   1        synchronous cancel of the current sweep
//  busy        out  1        high from the cycle after start is accepted until the cycle done pulses
//  face_cntr   out  AW       ROM address; drives ObjectMemory.face_cntr
//  rom_data    in   Face_t   ObjectMemory.face_data (valid 1 cycle after address issue)
//  face_valid  out  1        face_data/face_idx/face_last valid
//  face_ready  in   1        downstream accepts; handshake = face_valid & face_ready
//  face_data   out  Face_t   current face
//  face_idx    out  AW       index of face_data
//  face_last   out  1        face_idx == FACE_CNT-1
//  done        out  1        1-cycle pulse after the last face handshakes
// BEHAVIOUR
//  Reset: busy=0, face_valid=0, face_last=0, done=0, face_cntr=0, face_idx=0, FIFO empty, credits=0, state IDLE.
//  FSM states: IDLE, SWEEP, DRAIN.
//   IDLE  -> SWEEP on start & !abort; issue address register set to 0.
//   SWEEP -> DRAIN after address FACE_CNT-1 is issued.
//   DRAIN -> IDLE on handshake with face_last; done pulses that cycle+1 (registered), busy falls with done.
//  Issue rule:
//   - In SWEEP, issue the current address when (credits < 2) | handshake.
//   - credits = issued-not-yet-handshaken; range 0..2.
//   - The address increments on issue and holds otherwise.
//   - face_cntr equals the address register (combinational out).
//  Return: data issued in cycle N is written to the FIFO with its index at end of cycle N+1 (rom_data sampled then).
//  Output: FIFO head drives face_*; the FIFO pops on handshake; face_valid = !empty.
//  Latency: start sampled in T -> face_cntr=0 in T+1 -> face_valid=1 in T+3.
//  Throughput: with face_ready held high, 1 face/cycle and FACE_CNT consecutive valids.
//  Stall: face_data/face_idx hold stable while face_valid & !face_ready.
//   - The credit limit guarantees the FIFO never overflows.
//   - Writing to a full FIFO is an assertion failure.
//  Write and pop in the same cycle are both honoured; the count is unchanged.
//  face_idx wraps never; the sweep ends at FACE_CNT-1 and no address >= FACE_CNT is ever issued.
//  abort (any state, beats start):
//   - Next cycle: IDLE, FIFO flushed, credits=0, face_valid=0, busy=0.
//   - The in-flight ROM return is discarded.
//   - No done pulse.
//  start while busy, or start together with abort: ignored.
//  start in the cycle after done: accepted normally (back-to-back sweeps; no extra idle cycle).
//  rst mid-sweep: identical to abort, plus done forced 0.
// STRUCTURE
//  Primitives package gains:
//   - typedef enum logic [1:0] {SEQ_IDLE, SEQ_SWEEP, SEQ_DRAIN} SweepState_t;
//   - typedef struct packed {Face_t face; logic [AW-1:0] idx;} FaceTag_t (AW fixed by a FACE_ADDR_W localparam
//     derived from the mesh FACE_CNT).
//  Face_t is reused from Primitives; no local redefinition.
//  One sub-module: face_skid_fifo.
//   - 2-entry FaceTag_t FIFO with push, pop, flush, empty and full ports.
//   - Flush has priority over push.
//  FSM, address counter and credit counter are in the top module.
// TESTING
//  1. rst, start pulse, face_ready=1 -> face_valid first high 3 cycles later.
//     Then idx 0..91 on consecutive cycles, face_last at idx 91, done pulse next cycle, busy low with done.
//  2. face_ready toggled 1,0,0,1 pseudo-randomly (seeded).
//     Required: every idx 0..91 delivered exactly once, in order, and face_data == memory image[idx].
//     face_data stable during stalls; credits never exceed 2.
//  3. face_ready=0 from start -> face_cntr stops at 2 (addresses 0,1 issued), FIFO full, face_valid=1 idx 0.
//     Release -> remaining faces follow.
//  4. abort at face idx 40 while stalled -> next cycle face_valid=0, busy=0, no done.
//     A new start then yields idx 0 first.
//  5. start asserted continuously -> second sweep accepted the cycle after done.
//     start with abort in IDLE -> nothing issued.
//  6. rst asserted mid-sweep (idx 60) -> all outputs at reset values next cycle.
//     FACE_CNT=2 parameter build -> idx 0,1 then done.

Source files
------------

// File: rtl/face_sweep_sequencer_pkg.sv
// Shared primitives for the mesh-intersection pipeline: the face record,
// the sweep sequencer state encoding and the tagged face carried through
// the sequencer's skid buffer.
package face_sweep_sequencer_pkg;

    localparam int MESH_FACE_CNT = 92;
    localparam int FACE_ADDR_W   = $clog2(MESH_FACE_CNT);
    localparam int VERT_W        = 16;

    typedef struct packed {
        logic [VERT_W-1:0] v0;
        logic [VERT_W-1:0] v1;
        logic [VERT_W-1:0] v2;
    } Face_t;

    typedef enum logic [1:0] {SEQ_IDLE, SEQ_SWEEP, SEQ_DRAIN} SweepState_t;

    typedef struct packed {
        Face_t                  face;
        logic [FACE_ADDR_W-1:0] idx;
    } FaceTag_t;

endpackage

// File: rtl/face_sweep_sequencer_skid_fifo.sv
// Two-entry FIFO of tagged faces that absorbs the ROM read latency.
// Flush wins over push so an aborted sweep never leaves a stale entry.
module face_skid_fifo
    import face_sweep_sequencer_pkg::*;
(
    input  logic     i_clk,
    input  logic     i_rst,
    input  logic     i_push,
    input  FaceTag_t i_pushData,
    input  logic     i_pop,
    input  logic     i_flush,
    output FaceTag_t o_headData,
    output logic     o_empty,
    output logic     o_full
);

    FaceTag_t   r_mem [2];
    logic       r_wrPtr;
    logic       r_rdPtr;
    logic [1:0] r_count;
    logic       w_doPush;
    logic       w_doPop;

    assign o_empty    = (r_count == 2'd0);
    assign o_full     = (r_count == 2'd2);
    assign o_headData = r_mem[r_rdPtr];
    assign w_doPush   = i_push && !i_flush;
    assign w_doPop    = i_pop && !o_empty && !i_flush;

    // Pointer and occupancy bookkeeping; simultaneous push and pop keep the count.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wrPtr <= 1'b0;
            r_rdPtr <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= ~r_wrPtr;
            end
            if (w_doPop) begin
                r_rdPtr <= ~r_rdPtr;
            end
            r_count <= r_count + {1'b0, w_doPush} - {1'b0, w_doPop};
        end
    end

    // Storage array; contents are don't-care while the slot is empty.
    always_ff @(posedge i_clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_pushData;
        end
    end

    // Upstream credit limiting must never let a write land on a full buffer.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            assert (!(w_doPush && o_full && !w_doPop));
        end
    end

endmodule

// File: rtl/face_sweep_sequencer.sv
// Sweeps the ObjectMemory address range once per start and streams every
// face downstream on a valid/ready handshake. A credit counter caps the
// faces in flight (ROM pipeline plus skid buffer) at two.
module face_sweep_sequencer
    import face_sweep_sequencer_pkg::*;
#(
    parameter  int FACE_CNT = MESH_FACE_CNT,
    localparam int AW       = $clog2(FACE_CNT)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic          i_abort,
    output logic          o_busy,
    output logic [AW-1:0] o_face_cntr,
    input  Face_t         i_rom_data,
    output logic          o_face_valid,
    input  logic          i_face_ready,
    output Face_t         o_face_data,
    output logic [AW-1:0] o_face_idx,
    output logic          o_face_last,
    output logic          o_done
);

    SweepState_t   r_state;
    SweepState_t   w_stateNext;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] w_addrNext;
    logic [1:0]    r_credits;
    logic [1:0]    w_creditsNext;
    logic          r_inflight;
    logic [AW-1:0] r_inflightIdx;
    logic          r_done;
    logic          w_doneNext;
    logic          w_issue;
    logic          w_hs;
    logic          w_empty;
    logic          w_full;
    FaceTag_t      w_pushTag;
    FaceTag_t      w_headTag;

    assign w_hs             = !w_empty && i_face_ready;
    assign w_pushTag.face   = i_rom_data;
    assign w_pushTag.idx    = FACE_ADDR_W'(r_inflightIdx);

    assign o_busy       = (r_state != SEQ_IDLE);
    assign o_face_cntr  = r_addr;
    assign o_face_valid = !w_empty;
    assign o_face_data  = w_empty ? '0 : w_headTag.face;
    assign o_face_idx   = w_empty ? '0 : AW'(w_headTag.idx);
    assign o_face_last  = !w_empty && (w_headTag.idx == FACE_ADDR_W'(FACE_CNT - 1));
    assign o_done       = r_done;

    face_skid_fifo u_fifo (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_push     (r_inflight),
        .i_pushData (w_pushTag),
        .i_pop      (w_hs),
        .i_flush    (i_abort),
        .o_headData (w_headTag),
        .o_empty    (w_empty),
        .o_full     (w_full)
    );

    // Next-state, address issue and credit accounting; abort overrides everything.
    always_comb begin
        w_stateNext = r_state;
        w_addrNext  = r_addr;
        w_issue     = 1'b0;
        w_doneNext  = 1'b0;
        case (r_state)
            SEQ_IDLE: begin
                if (i_start && !i_abort) begin
                    w_stateNext = SEQ_SWEEP;
                    w_addrNext  = '0;
                end
            end
            SEQ_SWEEP: begin
                if ((r_credits < 2'd2) || w_hs) begin
                    w_issue = 1'b1;
                    if (r_addr == AW'(FACE_CNT - 1)) begin
                        w_stateNext = SEQ_DRAIN;
                    end else begin
                        w_addrNext = r_addr + 1'b1;
                    end
                end
            end
            SEQ_DRAIN: begin
                if (w_hs && o_face_last) begin
                    w_stateNext = SEQ_IDLE;
                    w_doneNext  = 1'b1;
                end
            end
            default: begin
                w_stateNext = SEQ_IDLE;
            end
        endcase
        w_creditsNext = r_credits + {1'b0, w_issue} - {1'b0, w_hs};
        if (i_abort) begin
            w_stateNext   = SEQ_IDLE;
            w_addrNext    = '0;
            w_issue       = 1'b0;
            w_doneNext    = 1'b0;
            w_creditsNext = 2'd0;
        end
    end

    // State, address, credit and ROM-return tracking registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= SEQ_IDLE;
            r_addr        <= '0;
            r_credits     <= 2'd0;
            r_inflight    <= 1'b0;
            r_inflightIdx <= '0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_stateNext;
            r_addr        <= w_addrNext;
            r_credits     <= w_creditsNext;
            r_inflight    <= w_issue;
            r_inflightIdx <= r_addr;
            r_done        <= w_doneNext;
        end
    end

    // A full skid buffer means both credits are parked in it.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            assert (!w_full || (r_credits == 2'd2));
        end
    end

endmodule

// File: tb/tb_face_sweep_sequencer.sv
// Bench for face_sweep_sequencer: a transaction-level model predicts busy,
// valid, done and the face stream; directed scenarios pin timing literals.
module tb_face_sweep_sequencer;
    import face_sweep_sequencer_pkg::*;

    localparam int N   = MESH_FACE_CNT;
    localparam int AWT = $clog2(N);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, start, abort, faceReady;
    logic           busy, faceValid, faceLast, done;
    logic [AWT-1:0] faceCntr, faceIdx;
    Face_t          romData, faceData;

    logic           rst2, start2, abort2, ready2;
    logic           busy2, valid2, last2, done2;
    logic [0:0]     cntr2, idx2;
    Face_t          rom2Data, data2;

    face_sweep_sequencer dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
        .o_busy(busy), .o_face_cntr(faceCntr), .i_rom_data(romData),
        .o_face_valid(faceValid), .i_face_ready(faceReady),
        .o_face_data(faceData), .o_face_idx(faceIdx),
        .o_face_last(faceLast), .o_done(done)
    );

    face_sweep_sequencer #(.FACE_CNT(2)) dut2 (
        .i_clk(clk), .i_rst(rst2), .i_start(start2), .i_abort(abort2),
        .o_busy(busy2), .o_face_cntr(cntr2), .i_rom_data(rom2Data),
        .o_face_valid(valid2), .i_face_ready(ready2),
        .o_face_data(data2), .o_face_idx(idx2),
        .o_face_last(last2), .o_done(done2)
    );

    function automatic Face_t faceImage(input int idx);
        Face_t f;
        f.v0 = 16'(idx * 3 + 17);
        f.v1 = 16'(idx) ^ 16'hBEEF;
        f.v2 = 16'(idx * 7919 + 5);
        return f;
    endfunction

    always @(posedge clk) begin
        romData  <= faceImage(int'(faceCntr));
        rom2Data <= faceImage(int'(cntr2));
    end

    int nVectors     = 0;
    int nMiscompares = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit s, input bit a, input bit r);
        start     = s;
        abort     = a;
        faceReady = r;
        @(negedge clk);
    endtask

    task automatic runUntilDone(input int maxCyc, input bit randReady, output int cycles);
        bit seen;
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < maxCyc) begin
            @(negedge clk);
            cycles++;
            if (done) seen = 1'b1;
            else faceReady = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (!seen) begin
            nVectors++;
            nMiscompares++;
            $display("[TB] FAIL done_timeout: got no done expected done within %0d cycles", maxCyc);
        end
    endtask

    // Model: a sweep is a count of delivered faces; valid rises two cycles
    // into the sweep and stays high until the last face handshakes.
    bit mBusy = 0, mDone = 0, mRst = 0, checkEn = 0, mValidNow = 0;
    int mAge = 0, mNext = 0;

    always @(posedge clk) begin
        mValidNow = mBusy && (mAge >= 2);
        if (rst) begin
            mBusy = 0; mAge = 0; mNext = 0; mDone = 0; mRst = 1; checkEn = 1;
        end else begin
            mRst  = 0;
            mDone = 0;
            if (abort) begin
                mBusy = 0; mAge = 0; mNext = 0;
            end else if (!mBusy) begin
                if (start) begin
                    mBusy = 1; mAge = 0; mNext = 0;
                end
            end else begin
                if (mAge < 2) mAge++;
                if (mValidNow && faceReady) begin
                    if (mNext == N - 1) begin
                        mBusy = 0;
                        mDone = 1;
                    end
                    mNext++;
                end
            end
        end
    end

    // Every cycle: compare the DUT against the model.
    always @(negedge clk) begin
        bit expValid;
        if (checkEn) begin
            expValid = mBusy && (mAge >= 2);
            checkOutput("busy", busy, mBusy);
            checkOutput("face_valid", faceValid, expValid);
            checkOutput("done", done, mDone);
            if (expValid) begin
                checkOutput("face_idx", faceIdx, mNext);
                checkOutput("face_data", faceData, faceImage(mNext));
                checkOutput("face_last", faceLast, mNext == N - 1);
            end
            if (mRst) begin
                checkOutput("rst_cntr", faceCntr, 0);
                checkOutput("rst_idx", faceIdx, 0);
                checkOutput("rst_last", faceLast, 0);
            end
            if (mBusy) begin
                checkOutput("credit_bound", int'(faceCntr) <= mNext + 2, 1);
                checkOutput("cntr_range", int'(faceCntr) < N, 1);
            end
        end
    end

    initial begin
        int k, cyc;
        bit hit;
        void'($urandom(32'd20240611));
        rst = 1; start = 0; abort = 0; faceReady = 0;
        rst2 = 1; start2 = 0; abort2 = 0; ready2 = 1;
        repeat (3) @(negedge clk);
        rst = 0; rst2 = 0;

        // 1: full-rate sweep, latency and length
        applyStimulus(1, 0, 1);
        start = 0;
        checkOutput("start_busy", busy, 1);
        checkOutput("start_cntr", faceCntr, 0);
        k = 1;
        while (!faceValid && k < 10) begin
            @(negedge clk);
            k++;
        end
        checkOutput("first_valid_latency", k, 3);
        runUntilDone(200, 0, cyc);
        checkOutput("valid_to_done", cyc, 92);
        checkOutput("busy_with_done", busy, 0);
        applyStimulus(0, 0, 1);

        // 2: random backpressure
        for (int s = 0; s < 2; s++) begin
            applyStimulus(1, 0, 1'($urandom_range(0, 1)));
            start = 0;
            runUntilDone(1000, 1, cyc);
            applyStimulus(0, 0, 1);
        end

        // 3: stalled from the start
        applyStimulus(1, 0, 0);
        start = 0;
        repeat (5) @(negedge clk);
        checkOutput("stall_cntr", faceCntr, 2);
        checkOutput("stall_valid", faceValid, 1);
        checkOutput("stall_idx", faceIdx, 0);
        checkOutput("stall_data", faceData, faceImage(0));
        runUntilDone(200, 0, cyc);
        applyStimulus(0, 0, 1);

        // 4: abort at idx 40 while stalled, then restart
        applyStimulus(1, 0, 1);
        start = 0;
        k = 0;
        hit = 0;
        while (!hit && k < 600) begin
            if (faceValid && faceIdx == 40) begin
                hit = 1;
                faceReady = 0;
                abort = 1;
            end else begin
                faceReady = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            k++;
        end
        checkOutput("abort_reached_idx40", hit, 1);
        checkOutput("abort_valid", faceValid, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        applyStimulus(0, 0, 1);
        checkOutput("abort_no_done", done, 0);
        applyStimulus(1, 0, 1);
        start = 0;
        k = 0;
        while (!faceValid && k < 10) begin
            @(negedge clk);
            k++;
        end
        checkOutput("restart_idx", faceIdx, 0);
        runUntilDone(200, 0, cyc);

        // 5: start held high gives back-to-back sweeps; start with abort is ignored
        start = 1;
        faceReady = 1;
        runUntilDone(300, 0, cyc);
        checkOutput("b2b_done_busy", busy, 0);
        @(negedge clk);
        checkOutput("b2b_accept", busy, 1);
        runUntilDone(300, 0, cyc);
        start = 0;
        applyStimulus(0, 0, 1);
        applyStimulus(1, 1, 1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 1);
            checkOutput("start_abort_busy", busy, 0);
            checkOutput("start_abort_valid", faceValid, 0);
        end

        // 6: reset mid-sweep at idx 60
        applyStimulus(1, 0, 1);
        start = 0;
        k = 0;
        while (!(faceValid && faceIdx == 60) && k < 200) begin
            @(negedge clk);
            k++;
        end
        checkOutput("rst_reached_idx60", faceIdx, 60);
        rst = 1;
        @(negedge clk);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_valid", faceValid, 0);
        checkOutput("midrst_done", done, 0);
        checkOutput("midrst_cntr", faceCntr, 0);
        checkOutput("midrst_idx", faceIdx, 0);
        checkOutput("midrst_last", faceLast, 0);
        rst = 0;
        applyStimulus(0, 0, 1);

        // 6b: two-face build
        start2 = 1;
        @(negedge clk);
        start2 = 0;
        for (int j = 1; j <= 6; j++) begin
            checkOutput("fc2_valid", valid2, (j == 3 || j == 4));
            if (j == 3 || j == 4) begin
                checkOutput("fc2_idx", idx2, j - 3);
                checkOutput("fc2_last", last2, j == 4);
                checkOutput("fc2_data", data2, faceImage(j - 3));
            end
            checkOutput("fc2_done", done2, j == 5);
            checkOutput("fc2_busy", busy2, j <= 4);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
